// File: rtl/record_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// rec_pkg
//   Shared types for the record deserializer:
//     rec_t        - default record assembled from lane beats (97 bits)
//     REC_IDLE_VAL - value presented on out_rec until the first record lands
//     state_e      - deserializer FSM states
//     ceil_div     - integer ceiling division used to size the beat count
// -----------------------------------------------------------------------------
package rec_pkg;

    typedef struct packed {
        logic x;
        int   y;
        time  z;
    } rec_t;

    localparam rec_t REC_IDLE_VAL = '{x: 1'b1, y: 32'sd7, z: 64'd10};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/record_deserializer.sv
// -----------------------------------------------------------------------------
// record_deserializer
//   Collects BEATS lane-wide beats (LSB-first) into one packed record of type
//   REC_T and presents it on a valid/ready output. Beat 0 of every record is
//   flagged by in_first; framing errors (a stray non-first beat while idle, or
//   a new first beat mid-record) raise a one-cycle err_pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   beat offered
//   in_ready   out  beat accepted when in_valid && in_ready
//   in_data    in   beat payload, LANE_W bits
//   in_first   in   beat is beat 0 of a record
//   out_valid  out  assembled record available
//   out_ready  in   consumer accepts the record
//   out_rec    out  assembled record (registered, separate from assembly buffer)
//   err_pulse  out  one-cycle framing-error strobe
// -----------------------------------------------------------------------------
module record_deserializer
    import rec_pkg::*;
#(
    parameter type  REC_T    = rec_pkg::rec_t,
    parameter REC_T IDLE_VAL = rec_pkg::REC_IDLE_VAL,
    parameter int   LANE_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_first,
    output logic              out_valid,
    input  logic              out_ready,
    output REC_T              out_rec,
    output logic              err_pulse
);

    localparam int REC_W = $bits(REC_T);
    localparam int BEATS = ceil_div(REC_W, LANE_W);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REC_W-1:0]   asm_q, asm_d;
    REC_T               rec_q, rec_d;
    logic               err_q, err_d;
    // Goes high on the first edge after reset release; gates in_ready so the
    // block never accepts beats while held in reset.
    logic               live_q;

    logic               accept_s;
    logic               open_s;
    int                 base_s;
    logic [REC_W-1:0]   lane_s;
    logic [REC_W-1:0]   mask_s;
    logic [REC_W-1:0]   merged_s;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = live_q && ((state_q != HOLD) || out_ready);
    assign accept_s  = in_valid && in_ready;
    // IDLE, or HOLD being released this cycle: both start a record the same way.
    assign open_s    = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign out_rec   = rec_q;
    assign err_pulse = err_q;

    // Beat placement: shift the lane into position; bits at or above REC_W
    // fall off the top of the shift, which discards final-beat padding.
    always_comb begin
        base_s   = in_first ? 0 : (int'(cnt_q) * LANE_W);
        lane_s   = REC_W'(in_data) << base_s;
        mask_s   = REC_W'({LANE_W{1'b1}}) << base_s;
        merged_s = (asm_q & ~mask_s) | lane_s;
    end

    // Next-state, counter, assembly buffer and output-record update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        rec_d   = rec_q;
        err_d   = 1'b0;

        if (state_q == COLLECT) begin
            if (accept_s && in_first) begin
                // New record interrupts the partial one: restart from beat 0.
                err_d = 1'b1;
                asm_d = merged_s;
                cnt_d = CNT_W'(1);
            end else if (accept_s && (cnt_q == LAST_CNT)) begin
                asm_d   = merged_s;
                rec_d   = REC_T'(merged_s);
                cnt_d   = '0;
                state_d = HOLD;
            end else if (accept_s) begin
                asm_d = merged_s;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                state_d = COLLECT;
            end
        end else if (open_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (accept_s && in_first) begin
                asm_d = merged_s;
                if (BEATS == 1) begin
                    rec_d   = REC_T'(merged_s);
                    state_d = HOLD;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = COLLECT;
                end
            end else if (accept_s) begin
                // Stray continuation beat with no record open: drop it.
                err_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == HOLD) begin
            state_d = HOLD;
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            rec_q   <= IDLE_VAL;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            rec_q   <= rec_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_record_deserializer.sv
// -----------------------------------------------------------------------------
// tb_record_deserializer
//   Drives the default 97-bit instance with directed and random records and
//   checks every cycle against a beat-queue reference model; also exercises an
//   int-typed instance with a fixed four-beat record.
// -----------------------------------------------------------------------------
module tb_record_deserializer;
    import rec_pkg::*;

    localparam int NB = 13;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_first, out_valid, out_ready, err_pulse;
    logic [7:0]  in_data;
    rec_t        out_rec;

    logic        i_in_valid, i_in_ready, i_in_first, i_out_valid, i_out_ready, i_err;
    logic [7:0]  i_in_data;
    int          i_out_rec;

    record_deserializer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first(in_first),
        .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec), .err_pulse(err_pulse)
    );

    record_deserializer #(.REC_T(int), .IDLE_VAL(32'sd50), .LANE_W(8)) dut_int (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i_in_valid), .in_ready(i_in_ready), .in_data(i_in_data), .in_first(i_in_first),
        .out_valid(i_out_valid), .out_ready(i_out_ready), .out_rec(i_out_rec), .err_pulse(i_err)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int sent_records = 0;
    int handshakes   = 0;
    bit rand_ordy    = 1'b0;

    task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model: beats queued per record ----------------
    logic [7:0]   mq[$];
    bit           m_hold  = 1'b0;
    bit           m_alive = 1'b0;
    bit           m_err   = 1'b0;
    logic [96:0]  m_rec   = REC_IDLE_VAL;

    initial begin : model
        bit           rdy;
        logic [103:0] w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_hold  = 1'b0;
                m_alive = 1'b0;
                m_err   = 1'b0;
                m_rec   = REC_IDLE_VAL;
            end else begin
                rdy   = m_alive && (!m_hold || out_ready);
                m_err = 1'b0;
                if (m_hold && out_ready) m_hold = 1'b0;
                if (in_valid && rdy) begin
                    if (in_first) begin
                        if (mq.size() != 0) m_err = 1'b1;
                        mq.delete();
                        mq.push_back(in_data);
                    end else if (mq.size() == 0) begin
                        m_err = 1'b1;
                    end else begin
                        mq.push_back(in_data);
                    end
                    if (mq.size() == NB) begin
                        w = '0;
                        for (int k = 0; k < NB; k++) w[k*8 +: 8] = mq[k];
                        m_rec  = w[96:0];
                        m_hold = 1'b1;
                        mq.delete();
                    end
                end
                m_alive = 1'b1;
            end
        end
    end

    // Per-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        chk_eq("in_ready",  in_ready,  m_alive && rst_n && (!m_hold || out_ready));
        chk_eq("out_valid", out_valid, m_hold);
        chk_eq("err_pulse", err_pulse, m_err);
        chk_eq("out_rec",   out_rec,   m_rec);
        if (rst_n && out_valid && out_ready) handshakes++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data  = 8'($urandom);
            in_first = 1'($urandom);
            tick();
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input bit f, input int gap);
        int waited;
        bit got;
        if (gap > 0) idle(gap);
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        waited   = 0;
        got      = 1'b0;
        while (!got && waited < 200) begin
            @(negedge clk);
            got = in_ready;
            tick();
            waited++;
        end
        if (!got) chk_eq("beat_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_beats(input logic [96:0] r, input int n, input int maxgap);
        logic [103:0] w;
        w = {7'b0, r};
        for (int k = 0; k < n; k++)
            send_beat(w[k*8 +: 8], (k == 0), (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        in_valid = 1'b0;
    endtask

    task automatic send_record(input logic [96:0] r, input int maxgap);
        send_beats(r, NB, maxgap);
        sent_records++;
    endtask

    function automatic logic [96:0] rand_rec();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[96:0];
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [96:0] ra, rb;
        logic [7:0]  ib [4];
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_first    = 1'b0;
        out_ready   = 1'b1;
        i_in_valid  = 1'b0;
        i_in_data   = 8'h00;
        i_in_first  = 1'b0;
        i_out_ready = 1'b1;
        ib[0] = 8'h78; ib[1] = 8'h56; ib[2] = 8'h34; ib[3] = 8'h12;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("int_reset_rec",   i_out_rec,  32'd50);
        chk_eq("int_reset_ready", i_in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Default record, back-to-back beats.
        send_record(REC_IDLE_VAL, 0);
        idle(3);

        // Consumer stalls 5 cycles with next record's first beat waiting.
        ra = rand_rec();
        rb = rand_rec();
        out_ready = 1'b0;
        send_record(ra, 0);
        in_valid = 1'b1;
        in_data  = rb[7:0];
        in_first = 1'b1;
        repeat (5) tick();
        out_ready = 1'b1;
        send_record(rb, 0);
        idle(3);

        // in_first re-asserted at beat 6 restarts the record.
        send_beats(rand_rec(), 6, 0);
        send_record(rand_rec(), 0);
        idle(3);

        // Stray continuation beat while idle.
        send_beat(8'h5A, 1'b0, 0);
        in_valid = 1'b0;
        idle(3);

        // Random records, gaps and back-pressure.
        rand_ordy = 1'b1;
        repeat (25) send_record(rand_rec(), 3);
        rand_ordy = 1'b0;
        out_ready = 1'b1;
        idle(5);

        // Asynchronous reset after beat 9.
        send_beats(rand_rec(), 10, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_valid", out_valid, 1'b0);
        chk_eq("arst_ready", in_ready,  1'b0);
        chk_eq("arst_err",   err_pulse, 1'b0);
        chk_eq("arst_rec",   out_rec,   REC_IDLE_VAL);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send_record(rand_rec(), 0);
        idle(5);

        // int-typed instance: four beats LSB-first.
        for (int k = 0; k < 4; k++) begin
            i_in_valid = 1'b1;
            i_in_first = (k == 0);
            i_in_data  = ib[k];
            @(negedge clk);
            chk_eq("int_ready", i_in_ready,  1'b1);
            chk_eq("int_early", i_out_valid, 1'b0);
            tick();
        end
        i_in_valid = 1'b0;
        @(negedge clk);
        chk_eq("int_valid", i_out_valid, 1'b1);
        chk_eq("int_rec",   i_out_rec,   32'h12345678);
        chk_eq("int_err",   i_err,       1'b0);
        tick();

        chk_eq("handshakes", handshakes, sent_records);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
